// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled mid-bit sampling, start-bit glitch filter,
// parity/framing/overrun reporting and a valid/ready output handshake.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk2,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    logic                 rx_meta;
    logic                 rxs;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 frm_q, frm_d;
    logic                 done;

    // Two-flop synchronizer; idle-high reset so a reset never looks like a start bit.
    always_ff @(posedge clk2) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            frm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            frm_q   <= frm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        frm_d   = frm_q;
        done    = 1'b0;

        if (sample_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        tick_d  = '0;
                        bit_d   = '0;
                        par_d   = 1'b0;
                        frm_d   = 1'b0;
                    end
                end

                // Re-check at the start-bit centre to reject short glitches.
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        par_d   = (PARITY_MODE == 2) ? ~(^shreg_q ^ rxs) : (^shreg_q ^ rxs);
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                // Word completes at the centre of the last stop bit so a following
                // start edge is caught even when frames are back-to-back.
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        frm_d  = frm_q | ~rxs;
                        if (bit_q == STOP_LAST) begin
                            done    = 1'b1;
                            bit_d   = '0;
                            state_d = frm_d ? WAIT_HIGH : IDLE;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg_q;
                parity_err <= par_q;
                frame_err  <= frm_d;
                rx_valid   <= 1'b1;
            end else if (done) begin
                overrun_err <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default/odd-parity instances share one rx line,
// a third instance runs 7O2 at 8x oversampling with a tick every third clock.
module tb_uart_rx_param;

    logic clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    logic rst, tick, rx, rx2, tick2, rdy;

    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic v0, pe0, fe0, ov0, busy0;
    logic v1, pe1, fe1, ov1, busy1;
    logic v2, pe2, fe2, ov2, busy2;

    uart_rx_param u_d0 (
        .clk2(clk2), .rst(rst), .sample_tick(tick), .rx(rx),
        .rx_data(data0), .rx_valid(v0), .rx_ready(rdy),
        .parity_err(pe0), .frame_err(fe0), .overrun_err(ov0), .busy(busy0)
    );

    uart_rx_param #(.PARITY_MODE(2)) u_d1 (
        .clk2(clk2), .rst(rst), .sample_tick(tick), .rx(rx),
        .rx_data(data1), .rx_valid(v1), .rx_ready(rdy),
        .parity_err(pe1), .frame_err(fe1), .overrun_err(ov1), .busy(busy1)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(8)) u_d2 (
        .clk2(clk2), .rst(rst), .sample_tick(tick2), .rx(rx2),
        .rx_data(data2), .rx_valid(v2), .rx_ready(rdy),
        .parity_err(pe2), .frame_err(fe2), .overrun_err(ov2), .busy(busy2)
    );

    int n_run = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Accepted-word and overrun monitors.
    int n0 = 0, n1 = 0, n2 = 0, nov0 = 0, nov1 = 0, nov2 = 0;
    logic [7:0] dat0 = '0, dat1 = '0;
    logic [6:0] dat2 = '0;
    logic p0 = 1'b0, f0 = 1'b0, p1 = 1'b0, f1 = 1'b0, p2 = 1'b0, f2 = 1'b0;

    always @(negedge clk2) begin
        if (v0 && rdy) begin n0 <= n0 + 1; dat0 <= data0; p0 <= pe0; f0 <= fe0; end
        if (v1 && rdy) begin n1 <= n1 + 1; dat1 <= data1; p1 <= pe1; f1 <= fe1; end
        if (v2 && rdy) begin n2 <= n2 + 1; dat2 <= data2; p2 <= pe2; f2 <= fe2; end
        if (ov0) nov0 <= nov0 + 1;
        if (ov1) nov1 <= nov1 + 1;
        if (ov2) nov2 <= nov2 + 1;
    end

    initial begin
        int div;
        div = 0;
        tick2 = 1'b0;
        forever begin
            @(negedge clk2);
            div = (div == 2) ? 0 : div + 1;
            tick2 = (div == 0);
        end
    end

    function automatic logic [15:0] fr0(input logic [7:0] d, input logic p, input logic s);
        return {5'b0, s, p, d, 1'b0};
    endfunction

    function automatic logic [15:0] fr2(input logic [6:0] d, input logic p);
        return {5'b0, 2'b11, p, d, 1'b0};
    endfunction

    task automatic send0(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (16) @(negedge clk2);
        end
    endtask

    task automatic send2(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx2 = bits[i];
            repeat (24) @(negedge clk2);
        end
    endtask

    initial begin
        int b0, b1, b2, bo0, bo1, bo2;
        rst = 1'b1; tick = 1'b1; rx = 1'b1; rx2 = 1'b1; rdy = 1'b1;
        repeat (4) @(negedge clk2);
        check_eq("rst_valid", {31'b0, v0}, 0);
        check_eq("rst_busy", {31'b0, busy0}, 0);
        check_eq("rst_data", {24'b0, data0}, 0);
        check_eq("rst_errs", {29'b0, pe0, fe0, ov0}, 0);
        check_eq("rst_busy2", {31'b0, busy2}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk2);

        // 1: clean 0xA5, busy drops before the end of the stop bit
        b0 = n0;
        send0(fr0(8'hA5, 1'b0, 1'b1), 10);
        rx = 1'b1;
        repeat (13) @(negedge clk2);
        check_eq("t1_busy_midstop", {31'b0, busy0}, 0);
        repeat (35) @(negedge clk2);
        check_eq("t1_count", n0 - b0, 1);
        check_eq("t1_data", {24'b0, dat0}, 32'hA5);
        check_eq("t1_errs", {30'b0, p0, f0}, 0);

        // 2: 0x01 with parity bit 0: bad for even, good for odd
        b0 = n0; b1 = n1;
        send0(fr0(8'h01, 1'b0, 1'b1), 11);
        repeat (32) @(negedge clk2);
        check_eq("t2_count", n0 - b0, 1);
        check_eq("t2_data", {24'b0, dat0}, 32'h01);
        check_eq("t2_even_pe", {30'b0, p0, f0}, 32'h2);
        check_eq("t2_odd_count", n1 - b1, 1);
        check_eq("t2_odd_data", {24'b0, dat1}, 32'h01);
        check_eq("t2_odd_pe", {30'b0, p1, f1}, 0);

        // 3: 4-tick glitch rejected
        b0 = n0; bo0 = nov0;
        rx = 1'b0;
        repeat (4) @(negedge clk2);
        rx = 1'b1;
        check_eq("t3_busy_start", {31'b0, busy0}, 1);
        repeat (8) @(negedge clk2);
        check_eq("t3_busy_idle", {30'b0, busy0, busy1}, 0);
        repeat (40) @(negedge clk2);
        check_eq("t3_no_word", n0 - b0, 0);
        check_eq("t3_no_ovr", nov0 - bo0, 0);

        // 4: framing error, stuck-low line, then recovery
        b0 = n0; b1 = n1;
        send0(fr0(8'h3C, 1'b0, 1'b0), 11);
        repeat (320) @(negedge clk2);
        check_eq("t4_wait_high", {31'b0, busy0}, 1);
        check_eq("t4_count", n0 - b0, 1);
        check_eq("t4_data", {24'b0, dat0}, 32'h3C);
        check_eq("t4_errs", {30'b0, p0, f0}, 32'h1);
        check_eq("t4_odd_fe", {31'b0, f1}, 1);
        rx = 1'b1;
        repeat (32) @(negedge clk2);
        check_eq("t4_busy_release", {31'b0, busy0}, 0);
        b0 = n0;
        send0(fr0(8'h55, 1'b0, 1'b1), 11);
        repeat (32) @(negedge clk2);
        check_eq("t4_clean_count", n0 - b0, 1);
        check_eq("t4_clean_data", {24'b0, dat0}, 32'h55);
        check_eq("t4_clean_errs", {30'b0, p0, f0}, 0);

        // 5: overrun while the consumer stalls
        rdy = 1'b0;
        b0 = n0; bo0 = nov0; bo1 = nov1;
        send0(fr0(8'h11, 1'b0, 1'b1), 11);
        send0(fr0(8'h22, 1'b0, 1'b1), 11);
        repeat (32) @(negedge clk2);
        check_eq("t5_valid_held", {31'b0, v0}, 1);
        check_eq("t5_data_held", {24'b0, data0}, 32'h11);
        check_eq("t5_overrun", nov0 - bo0, 1);
        check_eq("t5_overrun_odd", nov1 - bo1, 1);
        check_eq("t5_held_errs", {30'b0, pe0, fe0}, 0);
        #1 rdy = 1'b1;
        repeat (2) @(negedge clk2);
        check_eq("t5_valid_clear", {31'b0, v0}, 0);
        check_eq("t5_data_after", {24'b0, data0}, 32'h11);
        check_eq("t5_no_accept_lost", n0 - b0, 0);

        // 6: 7O2 at 8x, tick every third clock
        b2 = n2; bo2 = nov2;
        send2(fr2(7'h7F, 1'b0), 11);
        check_eq("t6_first_count", n2 - b2, 1);
        check_eq("t6_first_data", {25'b0, dat2}, 32'h7F);
        check_eq("t6_first_errs", {30'b0, p2, f2}, 0);
        send2(fr2(7'h00, 1'b1), 11);
        repeat (48) @(negedge clk2);
        check_eq("t6_second_count", n2 - b2, 2);
        check_eq("t6_second_data", {25'b0, dat2}, 32'h00);
        check_eq("t6_second_errs", {30'b0, p2, f2}, 0);
        check_eq("t6_no_overrun", nov2 - bo2, 0);

        send2(16'h000A, 4);
        rx2 = 1'b0;
        repeat (12) @(negedge clk2);
        check_eq("t6_busy_midframe", {31'b0, busy2}, 1);
        rst = 1'b1;
        rx2 = 1'b1;
        @(negedge clk2);
        check_eq("t6_rst_outs", {28'b0, v2, pe2, fe2, ov2}, 0);
        check_eq("t6_rst_busy", {31'b0, busy2}, 0);
        check_eq("t6_rst_data", {25'b0, data2}, 0);
        rst = 1'b0;
        repeat (72) @(negedge clk2);
        check_eq("t6_abandoned", n2 - b2, 2);
        send2(fr2(7'h2A, 1'b0), 11);
        repeat (48) @(negedge clk2);
        check_eq("t6_after_rst_count", n2 - b2, 3);
        check_eq("t6_after_rst_data", {25'b0, dat2}, 32'h2A);
        check_eq("t6_after_rst_errs", {30'b0, p2, f2}, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8-bit/even-parity receiver. Adds configurable data width, parity mode and stop bits, oversampled mid-bit sampling, and a start-bit glitch filter. Also adds framing, parity and overrun error reporting and a valid/ready output handshake. Sits between the pad-side rx line and the protocol/FIFO layer, and runs from a single system clock with a baud-rate sample enable.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; LSB received first
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; 1 or 2
OVERSAMPLE, 16, sample_tick pulses per bit period; even value, minimum 4

Ports:
clk2  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle enable at OVERSAMPLE x baud rate
rx  in  1  serial input, asynchronous to clk2, idle high
rx_data  out  DATA_BITS  received word, valid while rx_valid=1
rx_valid  out  1  word available; held until accepted
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
parity_err  out  1  parity mismatch for the presented word; qualified by rx_valid
frame_err  out  1  a stop bit sampled 0 for the presented word; qualified by rx_valid
overrun_err  out  1  one-cycle pulse when a completed word is dropped
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset values (synchronous, active-high):
  - rx passes through a 2-flop synchronizer; both flops reset to 1. All FSM logic uses the synchronized value rxs.
  - All outputs reset to 0. FSM goes to IDLE; tick and bit counters clear.
  - Reset mid-frame abandons the frame; no valid or error is produced for it.
- Timing:
  - Tick counter and FSM advance only on cycles with sample_tick=1. With sample_tick=0 all state holds.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - rxs=0 on a tick -> START, tick counter = 0.
- START:
  - On tick count OVERSAMPLE/2-1 (bit centre), sample rxs.
  - rxs=1 -> false start: return to IDLE, no flags.
  - rxs=0 -> clear tick counter, go to DATA.
- DATA:
  - Sample every OVERSAMPLE ticks (mid-bit); shift LSB-first into the shift register.
  - After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - Sample once.
  - Error when (^data ^ sampled) != 0 for even parity, or == 0 for odd parity.
  - Latch the result internally, then go to STOP.
- STOP:
  - Sample STOP_BITS bits at mid-bit; any 0 sets the frame-error latch.
  - At the last stop-bit sample the word completes. Go to IDLE if no frame error, else WAIT_HIGH.
  - Returning at mid-stop lets back-to-back frames be detected.
- WAIT_HIGH:
  - Stay until rxs=1 on a tick (break/stuck-low protection), then IDLE.
- Word completion (registered; outputs change on the clk2 edge after the completing tick):
  - If rx_valid=0, or rx_valid && rx_ready in the completing cycle: load rx_data, parity_err, frame_err; rx_valid=1.
  - Otherwise the old word and its flags are held, the new word is discarded, and overrun_err pulses for 1 cycle.
- Handshake:
  - rx_valid && rx_ready with no completion in the same cycle -> rx_valid=0 next cycle.
  - parity_err and frame_err follow rx_valid (cleared on accept).
  - rx_data holds its last value after accept.
- DATA_BITS < 9: upper unused shift bits are not present; rx_data is exactly DATA_BITS wide.

Test Plan:
1. Defaults, sample_tick tied 1, rx_ready=1; send 0xA5, parity bit 0, stop 1 -> rx_valid for 1 cycle, rx_data=0xA5, parity_err=0, frame_err=0, busy falls by mid-stop.
2. Defaults; send 0x01 with parity bit 0 -> rx_data=0x01, parity_err=1. Repeat with PARITY_MODE=2, bit 0 -> parity_err=0.
3. rx low for 4 ticks, then high -> no rx_valid, no errors; FSM back in IDLE after tick 7, busy=0.
4. Send 0x3C with stop bit 0, then hold rx low 20 bit times -> word 0x3C presented with frame_err=1; no further frames. Release rx, send 0x55 -> 0x55 received clean.
5. rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun_err pulses once at the second completion. Raise rx_ready -> 0x11 accepted, rx_valid=0.
6. DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2, OVERSAMPLE=8, tick every 3rd cycle; send 0x7F then 0x00 back-to-back -> both received, no errors. Assert rst during the 4th data bit of a third frame -> all outputs 0 next cycle; the following frame 0x2A is received correctly.
